// File: rtl/uart_msg_seq_pkg.sv
// Shared state encoding and default message contents for the UART message sequencer.
package uart_msg_seq_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_MSG_LEN    = 15;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_ACK,
    WAIT_DONE,
    GAP
  } seq_state_t;

  // "Hello, world!\r\n"; anything past the end reads as zero.
  function automatic logic [7:0] default_msg_byte(input logic [8:0] idx);
    case (idx)
      9'd0:    return 8'h48;
      9'd1:    return 8'h65;
      9'd2:    return 8'h6C;
      9'd3:    return 8'h6C;
      9'd4:    return 8'h6F;
      9'd5:    return 8'h2C;
      9'd6:    return 8'h20;
      9'd7:    return 8'h77;
      9'd8:    return 8'h6F;
      9'd9:    return 8'h72;
      9'd10:   return 8'h6C;
      9'd11:   return 8'h64;
      9'd12:   return 8'h21;
      9'd13:   return 8'h0D;
      9'd14:   return 8'h0A;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/uart_msg_seq_if.sv
// Byte handshake between the message sequencer (master) and the UART transmitter (slave).
interface uart_msg_seq_if
  import uart_msg_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] load_byte;
  logic                  load;
  logic                  ready;

  modport master (output load_byte, output load, input ready);
  modport slave  (input load_byte, input load, output ready);

endinterface

// File: rtl/uart_msg_seq_rom.sv
// Combinational message ROM: index in, message byte out.
module uart_msg_seq_rom
  import uart_msg_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MSG_LEN    = DEFAULT_MSG_LEN,
  localparam int IDX_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic [IDX_W-1:0]      addr,
  output logic [DATA_WIDTH-1:0] data
);

  always_comb begin
    data = '0;
    if (32'(addr) < MSG_LEN) begin
      data = DATA_WIDTH'(default_msg_byte(9'(addr)));
    end
  end

endmodule

// File: rtl/uart_msg_seq.sv
// Steps through the ROM message, handing each byte to the transmitter over load/ready,
// and repeats the message with an idle gap while enabled.
module uart_msg_seq
  import uart_msg_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MSG_LEN    = DEFAULT_MSG_LEN,
  parameter int GAP_CYCLES = 96
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  uart_msg_seq_if.master        tx,
  output logic                  busy,
  output logic                  msg_done,
  output logic [15:0]           msg_count
);

  localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

  seq_state_t            state;
  logic [IDX_W-1:0]      index;
  logic [IDX_W-1:0]      rom_addr;
  logic [GAP_W-1:0]      gap_cnt;
  logic [DATA_WIDTH-1:0] rom_data;
  logic [DATA_WIDTH-1:0] load_byte;
  logic                  load;

  // The ROM is addressed with the byte about to be loaded so load_byte can be registered.
  assign rom_addr = (state == WAIT_DONE) ? index + IDX_W'(1) : '0;

  uart_msg_seq_rom #(
    .DATA_WIDTH (DATA_WIDTH),
    .MSG_LEN    (MSG_LEN)
  ) u_rom (
    .addr (rom_addr),
    .data (rom_data)
  );

  assign tx.load      = load;
  assign tx.load_byte = load_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      index     <= '0;
      gap_cnt   <= '0;
      load      <= 1'b0;
      load_byte <= '0;
      busy      <= 1'b0;
      msg_done  <= 1'b0;
      msg_count <= '0;
    end else begin
      load     <= 1'b0;
      msg_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && tx.ready) begin
            index     <= '0;
            load_byte <= rom_data;
            load      <= 1'b1;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!tx.ready) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (tx.ready) begin
            if (index != LAST_IDX) begin
              index     <= index + IDX_W'(1);
              load_byte <= rom_data;
              load      <= 1'b1;
              state     <= LOAD;
            end else begin
              msg_done  <= 1'b1;
              busy      <= 1'b0;
              msg_count <= msg_count + 16'd1;
              gap_cnt   <= GAP_LOAD;
              state     <= (GAP_CYCLES == 0) ? IDLE : GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt <= GAP_W'(1)) begin
            gap_cnt <= '0;
            state   <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_msg_seq.sv
// Self-checking bench for uart_msg_seq: randomized transmitter timing against a
// message-level reference model of the expected byte stream and handshake rules.
module tb_uart_msg_seq;

  localparam int MSG_LEN    = 15;
  localparam int GAP_CYCLES = 96;
  localparam int BUDGET     = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        busy;
  logic        msg_done;
  logic [15:0] msg_count;

  uart_msg_seq_if #(.DATA_WIDTH(8)) tx_bus ();

  uart_msg_seq #(
    .DATA_WIDTH (8),
    .MSG_LEN    (MSG_LEN),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .tx        (tx_bus),
    .busy      (busy),
    .msg_done  (msg_done),
    .msg_count (msg_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  ref_msg [MSG_LEN];
  logic [15:0] exp_count = '0;
  int  cyc = 0, pos = 0, load_total = 0, done_total = 0;
  int  done_cycle = 0, rise_cycle = -100, last_load_cycle = 0;
  bit  first_load = 1'b1, seen_low = 1'b0, seen_high = 1'b0, lb_changed = 1'b0;
  bit  done_valid = 1'b0, enable_dropped = 1'b0, prev_load = 1'b0, prev_ready = 1'b1;
  bit  tx_hold = 1'b0;
  logic [7:0] last_byte = '0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic en, input int cycles);
    enable = en;
    repeat (cycles) tick();
  endtask

  task automatic wait_loads(input int target, input string tag);
    int n = 0;
    while (load_total < target && n < BUDGET) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(load_total >= target), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    int start = done_total;
    while (done_total == start && n < BUDGET) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(done_total != start), 32'd1);
  endtask

  // Transmitter model: takes each byte after a random delay, stays busy for a random frame.
  initial begin : tx_model
    int ack;
    int frame;
    tx_bus.ready = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_bus.load && !rst) begin
        ack     = int'($urandom_range(3, 0));
        frame   = tx_hold ? 200 : int'($urandom_range(12, 2));
        tx_hold = 1'b0;
        repeat (ack) @(negedge clk);
        tx_bus.ready = 1'b0;
        repeat (frame) @(negedge clk);
        tx_bus.ready = 1'b1;
      end
    end
  end

  // Reference model: every load must carry the next message character, follow a full
  // ready low/high cycle, and every message must end after exactly MSG_LEN loads.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (rst) begin
        pos        = 0;
        exp_count  = '0;
        first_load = 1'b1;
        seen_low   = 1'b0;
        seen_high  = 1'b0;
        lb_changed = 1'b0;
        done_valid = 1'b0;
        prev_load  = 1'b0;
        prev_ready = tx_bus.ready;
      end else begin
        if (!enable) enable_dropped = 1'b1;
        if (tx_bus.ready && !prev_ready) rise_cycle = cyc;
        if (tx_bus.load) begin
          checkOutput("no_back_to_back_load", 32'(prev_load), 32'd0);
          if (!first_load) checkOutput("load_after_ready_low_high", 32'(seen_low && seen_high), 32'd1);
          if (pos < MSG_LEN) checkOutput($sformatf("byte_%0d", pos), 32'(tx_bus.load_byte), 32'(ref_msg[pos]));
          else checkOutput("load_count_in_msg", 32'(pos + 1), 32'(MSG_LEN));
          checkOutput("busy_on_load", 32'(busy), 32'd1);
          if (pos > 0) checkOutput("load_after_ready_rise", 32'(cyc - rise_cycle), 32'd1);
          else if (done_valid && !enable_dropped)
            checkOutput("gap_to_next_msg", 32'(cyc - done_cycle), 32'(GAP_CYCLES + 1));
          pos++;
          load_total++;
          first_load      = 1'b0;
          seen_low        = 1'b0;
          seen_high       = 1'b0;
          last_byte       = tx_bus.load_byte;
          last_load_cycle = cyc;
        end else begin
          if (!tx_bus.ready) seen_low = 1'b1;
          else if (seen_low) seen_high = 1'b1;
          if (!first_load && tx_bus.load_byte !== last_byte) lb_changed = 1'b1;
        end
        if (msg_done) begin
          exp_count++;
          checkOutput("bytes_per_msg", 32'(pos), 32'(MSG_LEN));
          checkOutput("busy_at_done", 32'(busy), 32'd0);
          checkOutput("msg_count", 32'(msg_count), 32'(exp_count));
          checkOutput("load_byte_stable", 32'(lb_changed), 32'd0);
          pos            = 0;
          done_cycle     = cyc;
          done_valid     = 1'b1;
          enable_dropped = 1'b0;
          done_total++;
        end
        prev_load  = tx_bus.load;
        prev_ready = tx_bus.ready;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    string s;
    int base;
    int t4;
    s = "Hello, world!\r\n";
    for (int i = 0; i < MSG_LEN; i++) ref_msg[i] = s[i];
    rst    = 1'b1;
    enable = 1'b0;
    repeat (3) tick();

    checkOutput("reset_load", 32'(tx_bus.load), 32'd0);
    checkOutput("reset_load_byte", 32'(tx_bus.load_byte), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_msg_done", 32'(msg_done), 32'd0);
    checkOutput("reset_msg_count", 32'(msg_count), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 3);
    checkOutput("disabled_no_load", 32'(load_total), 32'd0);

    // First message: load must follow enable by exactly one clock.
    applyStimulus(1'b1, 1);
    checkOutput("start_latency_load", 32'(tx_bus.load), 32'd1);
    checkOutput("start_byte", 32'(tx_bus.load_byte), 32'h48);
    checkOutput("busy_rise", 32'(busy), 32'd1);
    wait_done("msg1_done_seen");
    checkOutput("msg1_count", 32'(msg_count), 32'd1);
    checkOutput("msg1_loads", 32'(load_total), 32'(MSG_LEN));

    wait_done("msg2_done_seen");
    checkOutput("msg2_count", 32'(msg_count), 32'd2);

    // Enable dropped mid-message: the message still completes, then nothing more.
    base = load_total;
    wait_loads(base + 5, "drop_reach_byte5");
    enable = 1'b0;
    wait_done("drop_done_seen");
    checkOutput("drop_full_msg", 32'(load_total - base), 32'(MSG_LEN));
    base = load_total;
    applyStimulus(1'b0, 200);
    checkOutput("drop_no_more_loads", 32'(load_total), 32'(base));
    checkOutput("drop_busy_low", 32'(busy), 32'd0);

    // Long transmitter frame on the fourth byte, then a reset during byte 7.
    base = load_total;
    enable = 1'b1;
    wait_loads(base + 3, "hold_reach_byte3");
    tx_hold = 1'b1;
    wait_loads(base + 4, "hold_reach_byte4");
    t4 = last_load_cycle;
    wait_loads(base + 5, "hold_reach_byte5");
    checkOutput("hold_no_early_load", 32'((last_load_cycle - t4) > 200), 32'd1);
    wait_loads(base + 7, "rst_reach_byte7");
    rst = 1'b1;
    tick();
    checkOutput("rst_load", 32'(tx_bus.load), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_msg_count", 32'(msg_count), 32'd0);
    rst = 1'b0;
    base = load_total;
    wait_loads(base + 1, "rst_restart_seen");
    checkOutput("rst_first_byte", 32'(tx_bus.load_byte), 32'h48);
    wait_done("rst_msg_done_seen");
    checkOutput("rst_msg_count_after", 32'(msg_count), 32'd1);

    // Counter wrap: preset to all ones during the gap, one more message rolls it to zero.
    tick();
    force u_dut.msg_count = 16'hFFFF;
    exp_count = 16'hFFFF;
    tick();
    release u_dut.msg_count;
    wait_done("wrap_done_seen");
    checkOutput("count_wrap", 32'(msg_count), 32'd0);
    applyStimulus(1'b0, 150);
    checkOutput("final_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
